// File: rtl/music_pkg.sv
// Shared definitions for the audio playback path: FSM states, default flash
// region bounds and the command characters also used by the keyboard decoder.
// No ports; imported by music_address_generator and its sub-module.
package music_pkg;

  // Playback sequencer states
  typedef enum logic [2:0] {
    FETCH,
    WAIT_DATA,
    EMIT0,
    EMIT1,
    ADVANCE
  } state_t;

  // Flash word-address width and default audio region (inclusive bounds)
  localparam int                    ADDR_W_DEF     = 23;
  localparam logic [ADDR_W_DEF-1:0] START_ADDR_DEF = 23'h000000;
  localparam logic [ADDR_W_DEF-1:0] END_ADDR_DEF   = 23'h07FFFF;

  // Keyboard command characters (ASCII) understood by the command decoder
  localparam logic [7:0] KEY_B = 8'h42;  // play backward
  localparam logic [7:0] KEY_D = 8'h44;  // pause
  localparam logic [7:0] KEY_E = 8'h45;  // start / resume
  localparam logic [7:0] KEY_F = 8'h46;  // play forward
  localparam logic [7:0] KEY_R = 8'h52;  // restart from region start

endpackage

// File: rtl/flash_word_fetcher.sv
// Purpose: owns the flash read/readdatavalid handshake for one word at a time,
//   dropping the returning word when a restart hit while it was in flight.
// Latency: flash_read rises the edge after fetch_go; word_valid is combinational
//   with flash_readdatavalid. Backpressure: none -- one outstanding read, and
//   flash_read is held until the flash answers.
// Ports: fetch_go/fetch_addr start a read; restart marks the in-flight word
//   for discard; word_valid/word present an accepted word; fetch_done flags
//   that the outstanding read retired (kept or discarded).
module flash_word_fetcher
  import music_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_go,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic              fetch_done,
  output logic              word_valid,
  output logic [31:0]       word
);

  logic discard;

  // A strobe only counts while a read is outstanding; strays are ignored.
  assign fetch_done = flash_read & flash_readdatavalid;
  // A restart in the same cycle as the data also throws the word away.
  assign word_valid = fetch_done & ~discard & ~restart;
  assign word       = flash_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_read <= 1'b0;
      flash_addr <= RESET_ADDR;
      discard    <= 1'b0;
    end else begin
      if (fetch_go) begin
        flash_read <= 1'b1;
        flash_addr <= fetch_addr;
      end else if (fetch_done) begin
        flash_read <= 1'b0;
      end

      if (fetch_done) begin
        discard <= 1'b0;
      end else if (restart && flash_read) begin
        discard <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/music_address_generator.sv
// Purpose: walks flash word addresses through the audio region, fetches each
//   32-bit word and plays it out as two 16-bit samples, one per sample tick.
// Latency: audio_valid/audio_sample update the edge after a serviceable tick.
//   Backpressure: none -- a tick with no sample ready is held one-deep, and a
//   second such tick is lost and flagged on the sticky underrun output.
// Ports: clk/reset; forward/start levels and restart pulse from the command
//   decoder; sample_tick; flash_read/flash_addr/flash_readdata/
//   flash_readdatavalid to flash; audio_sample/audio_valid/underrun out.
module music_address_generator
  import music_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(END_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              forward,
  input  logic              start,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              audio_valid,
  output logic              underrun
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;        // address of the word being played / fetched next
  logic              dir;         // direction latched when the word was captured
  logic [31:0]       word_buf;
  logic              pending;     // one tick received while no sample was ready

  logic              fetch_go;
  logic              fetch_done;
  logic              word_valid;
  logic [31:0]       word;

  logic              serv_tick;
  logic              emit_state;
  logic              do_emit;
  logic [ADDR_W-1:0] restart_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [15:0]       emit_sample;

  flash_word_fetcher #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (START_ADDR)
  ) u_fetcher (
    .clk                 (clk),
    .reset               (reset),
    .fetch_go            (fetch_go),
    .fetch_addr          (addr),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_addr          (flash_addr),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .fetch_done          (fetch_done),
    .word_valid          (word_valid),
    .word                (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fetch_go     = 1'b0;
    // restart wins over a coincident tick; paused ticks are simply dropped
    serv_tick    = sample_tick & start & ~restart;
    emit_state   = (state == EMIT0) || (state == EMIT1);
    do_emit      = emit_state & start & ~restart & (pending | serv_tick);
    restart_addr = forward ? START_ADDR : END_ADDR;
    emit_sample  = '0;

    if (forward) begin
      step_addr = (addr == END_ADDR) ? START_ADDR : addr + ADDR_W'(1);
    end else begin
      step_addr = (addr == START_ADDR) ? END_ADDR : addr - ADDR_W'(1);
    end

    // dir=1 plays the low half first, dir=0 the high half first
    if (state == EMIT0) begin
      emit_sample = dir ? word_buf[15:0] : word_buf[31:16];
    end else begin
      emit_sample = dir ? word_buf[31:16] : word_buf[15:0];
    end

    case (state)
      FETCH: begin
        // a restart here holds off the request until the new address is loaded
        if (!restart) begin
          fetch_go   = 1'b1;
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // an in-flight read must retire before refetching; a discarded word
        // sends us back to FETCH at the (restart) address
        if (fetch_done) begin
          state_next = word_valid ? EMIT0 : FETCH;
        end
      end
      EMIT0: begin
        if (restart) begin
          state_next = FETCH;
        end else if (do_emit) begin
          state_next = EMIT1;
        end
      end
      EMIT1: begin
        if (restart) begin
          state_next = FETCH;
        end else if (do_emit) begin
          state_next = ADVANCE;
        end
      end
      ADVANCE: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr         <= START_ADDR;
      dir          <= 1'b1;
      word_buf     <= '0;
      pending      <= 1'b0;
      audio_sample <= '0;
      audio_valid  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      audio_valid <= do_emit;
      if (do_emit) begin
        audio_sample <= emit_sample;
      end

      if (word_valid) begin
        word_buf <= word;
        dir      <= forward;
      end

      if (restart) begin
        addr <= restart_addr;
      end else if (state == ADVANCE) begin
        addr <= step_addr;
      end

      // In EMIT states a pending tick is consumed; if a fresh tick arrives in
      // the same cycle it takes the pending slot so neither is lost.
      if (restart || !start) begin
        pending <= 1'b0;
      end else if (emit_state) begin
        pending <= pending & serv_tick;
      end else if (serv_tick) begin
        pending <= 1'b1;
        if (pending) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/music_address_generator.md
Name: music_address_generator

Overview:
- Sits directly downstream of the keyboard command decoder.
- Consumes its forward/start levels plus a restart pulse, and walks flash word addresses through the audio region.
- Fetches 32-bit words over a read/readdatavalid handshake and splits each word into two 16-bit samples.
- Emits one sample per sample_tick to the audio output stage.

Parameters:
- ADDR_W, 23, flash word-address width
- START_ADDR, 23'h000000, first word of audio region
- END_ADDR, 23'h07FFFF, last word of audio region (inclusive); END_ADDR > START_ADDR

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- forward  in  1  level; 1 = forward playback, 0 = backward
- start  in  1  level; 1 = play, 0 = pause
- restart  in  1  single-cycle pulse; jump to region start for the current direction
- sample_tick  in  1  single-cycle pulse at the audio sample rate
- flash_read  out  1  read request, held until flash_readdatavalid
- flash_addr  out  ADDR_W  word address, stable while flash_read = 1
- flash_readdata  in  32  read data, valid with flash_readdatavalid
- flash_readdatavalid  in  1  single-cycle data strobe
- audio_sample  out  16  current sample, held between updates
- audio_valid  out  1  one-cycle pulse when audio_sample updates
- underrun  out  1  sticky; a tick arrived while no buffered sample was available

Behaviour:
- Reset values: flash_read=0, flash_addr=START_ADDR, audio_sample=0, audio_valid=0, underrun=0, buffer empty, pending tick cleared, dir register=1. State goes to FETCH.
- Reset mid-read: flash_read drops the cycle after reset. A flash_readdatavalid arriving outside WAIT_DATA is ignored.
- States and transitions:
  - FETCH: drive flash_read=1 with flash_addr, then go to WAIT_DATA.
  - WAIT_DATA: on flash_readdatavalid, capture the word, drop flash_read that same edge, latch dir=forward, then go to EMIT0.
  - EMIT0: wait for a serviceable tick, then output the first half-sample and go to EMIT1.
  - EMIT1: wait for a serviceable tick, then output the second half-sample and go to ADVANCE.
  - ADVANCE: one cycle. Compute the next address, then go to FETCH.
- Sample order:
  - dir=1: first = readdata[15:0], second = readdata[31:16].
  - dir=0: first = readdata[31:16], second = readdata[15:0].
- Direction: sampled only at word capture (for sample order) and in ADVANCE (for stepping). Toggling forward mid-word never reorders the current word.
- Address step:
  - forward=1: addr+1; if addr==END_ADDR, wrap to START_ADDR.
  - forward=0: addr-1; if addr==START_ADDR, wrap to END_ADDR.
- Tick service rule: a tick is serviceable only if start=1 in the tick cycle. Ticks with start=0 are dropped and do not set underrun.
- Emit latency: audio_sample and audio_valid update on the edge after a serviceable tick in EMIT0/EMIT1.
- Tick during FETCH or WAIT_DATA (start=1):
  - It is stored as a one-deep pending tick.
  - The pending tick is serviced in the first EMIT0 cycle, so audio_valid pulses in the cycle after entering EMIT0.
  - A second tick while pending is already set is lost and sets underrun.
  - Clearing start clears the pending tick.
- Pause (start=0): fetch activity still completes, and the FSM parks in EMIT0 or EMIT1. Address and buffered word are retained, and playback resumes exactly where it stopped.
- restart:
  - Sets the next fetch address to START_ADDR if forward=1, else END_ADDR.
  - Discards the buffered word and any pending tick.
  - If in WAIT_DATA: stays there, the returning data is discarded, then goes to FETCH at the new address.
  - Otherwise: goes to FETCH on the next edge.
  - restart in the same cycle as flash_readdatavalid: the data is discarded.
- restart and sample_tick in the same cycle: restart wins and the tick is dropped.
- underrun clears only on reset.

Decomposition:
- Package music_pkg holds:
  - state enum (FETCH, WAIT_DATA, EMIT0, EMIT1, ADVANCE)
  - ADDR_W and default region bounds
  - keyboard character constants shared with the command decoder (B, D, E, F, R)
- One sub-module, flash_word_fetcher, owns the read/readdatavalid handshake and the discard-on-restart flag. It exposes fetch_go, fetch_addr, word_valid and word. Sample selection and address stepping stay in the top module.

Test Plan:
- Forward, END_ADDR=3: reset, start=1, forward=1, words W0..W3 = 32'hAAAA5555 pattern, tick every 20 cycles → addresses 0,1,2,3,0, samples low-then-high, audio_valid exactly one cycle after each tick.
- Backward wrap: forward=0 from reset → first fetch at 0, next at 3 (END), samples high-then-low; flip forward to 1 during EMIT1 of word 3 → next fetch is 0 (END+1 wraps to START), order switches at next capture.
- Pause/resume: start=0 after the 3rd sample, 5 ticks, start=1 → no audio_valid while paused, 4th sample is the next half of the same word, underrun=0.
- Slow flash: readdatavalid 30 cycles after request, ticks every 10 cycles → one tick serviced on entering EMIT0, underrun=1, sticky until reset.
- restart during WAIT_DATA with forward=1 at addr 2: in-flight data discarded, next flash_addr=0, first emitted sample = word 0 low half.
- Reset mid-read: reset while flash_read=1 → flash_read=0 next cycle, later flash_readdatavalid ignored, fetch restarts at START_ADDR with audio_sample=0.
